fp_linear_decoder: RTL
======================

// Module: fp_linear_decoder
// PURPOSE
//  Inverse of the linear-to-float compressor. Expands an 8-bit float code
//  (sign, 3-bit exponent, 4-bit significand) back to a 12-bit two's-complement sample.
//  Valid/ready on both sides. Bit-serial shifter: one shift per cycle.
//  Sits downstream of the encoder/transport and feeds the linear-sample datapath.
// PARAMETERS
//  EXP_W  3   exponent width
//  SIG_W  4   significand width
//  OUT_W  12  output sample width
//         Constraint: OUT_W >= SIG_W + 2**EXP_W; elaboration fails otherwise.
// PORTS
//  clk        in   1      single clock; all logic on posedge
//  rst        in   1      synchronous reset, active-high
//  in_valid   in   1      input code valid
//  in_ready   out  1      decoder can accept a code
//  in_sign    in   1      1 = negative
//  in_exp     in   EXP_W  shift amount, 0..7
//  in_sig     in   SIG_W  unsigned significand
//  out_valid  out  1      out_data holds a finished sample
//  out_ready  in   1      downstream accepts out_data
//  out_data   out  OUT_W  two's-complement sample
//  busy       out  1      high in any state other than IDLE
// BEHAVIOUR
//  - Value: mag = in_sig << in_exp, zero-extended to OUT_W-1 bits.
//    out_data = in_sign ? -mag : mag. Max |value| = 15<<7 = 1920, so no overflow.
//    sign=1 with sig=0 gives 0; no negative zero.
//  - FSM states: IDLE, SHIFT, DONE.
//  - IDLE: in_ready=1. On in_valid & in_ready:
//    mag <= in_sig; cnt <= in_exp; sgn <= in_sign; go to SHIFT.
//  - SHIFT: in_ready=0.
//    If cnt != 0: mag <= mag << 1; cnt <= cnt - 1.
//    If cnt == 0: out_data <= sgn ? (~mag + 1) : mag; go to DONE.
//  - DONE: out_valid=1; out_data held stable.
//    On out_ready: go to IDLE. No input is accepted in that same cycle.
//  - Latency: code accepted at edge N -> out_valid high after edge N+exp+1.
//    exp=0 gives 1 cycle; exp=7 gives 8 cycles.
//    Throughput: one code per exp+3 cycles with out_ready held high.
//  - in_ready and out_valid are decoded from the state register only.
//    Neither output depends combinationally on any input.
//  - Upstream holds in_* stable while in_valid & !in_ready.
//    in_* are sampled only on the accept edge.
//  - Reset: state=IDLE, out_valid=0, out_data=0, mag=0, cnt=0, sgn=0.
//    in_ready=0 and busy=0 while rst is high; in_ready=1 on the first cycle after release.
//    Reset mid-SHIFT or mid-DONE discards the sample; no stale out_valid after release.
//  - in_valid with out_ready in any state never causes a double accept or a dropped sample.
// STRUCTURE
//  - Shared package: FP_EXP_W=3, FP_SIG_W=4, LIN_W=12, plus the state encoding
//    (IDLE=2'd0, SHIFT=2'd1, DONE=2'd2).
//    The same width constants are used by the encoder.
//  - Single module; no sub-module is needed.
//    Shift/count datapath and FSM: about 150 lines.
//  - Unused state 2'd3 recovers to IDLE.
// TESTING
//  1. sign=0, exp=0, sig=4'b0101 -> out_data=12'h005; out_valid 1 cycle after accept.
//  2. sign=0, exp=7, sig=4'b1111 -> out_data=12'h780 (1920); out_valid 8 cycles after accept.
//  3. sign=1, exp=3, sig=4'b1010 -> out_data=12'hFB0 (-80).
//  4. sign=1, exp=5, sig=4'b0000 -> out_data=12'h000.
//  5. Code from test 3, out_ready=0 for 5 cycles -> out_data stays 12'hFB0, in_ready=0.
//     Then out_ready=1 -> IDLE next cycle; next code accepted.
//  6. rst pulsed during SHIFT of exp=6 -> out_valid=0 and out_data=0 after reset;
//     in_ready=1 the cycle after release; the following code decodes correctly.

Source files
------------

// File: rtl/fp_linear_decoder_pkg.sv
// +---------------------------------------------------------------------------+
// | fp_linear_decoder_pkg : shared float-code widths and decoder FSM encoding |
// | Rev 1.0                                                                   |
// +---------------------------------------------------------------------------+
`default_nettype none

package fp_linear_decoder_pkg;

  // Code and sample widths, also used by the matching encoder.
  localparam int FP_EXP_W = 3;
  localparam int FP_SIG_W = 4;
  localparam int LIN_W    = 12;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

endpackage

`default_nettype wire

// File: rtl/fp_linear_decoder.sv
// +---------------------------------------------------------------------------+
// | fp_linear_decoder : expands sign/exp/sig float code to a two's-complement |
// | sample with a bit-serial shifter. Rev 1.0                                 |
// +---------------------------------------------------------------------------+
`default_nettype none

module fp_linear_decoder
  import fp_linear_decoder_pkg::*;
#(
  parameter int EXP_W = FP_EXP_W,
  parameter int SIG_W = FP_SIG_W,
  parameter int OUT_W = LIN_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_sign,
  input  logic [EXP_W-1:0] in_exp,
  input  logic [SIG_W-1:0] in_sig,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_data,
  output logic             busy
);

  if (OUT_W < SIG_W + 2**EXP_W) begin : g_width_check
    $error("fp_linear_decoder: OUT_W too small for SIG_W and EXP_W");
  end

  state_e             state_q, state_d;
  logic [OUT_W-1:0]   mag_q, mag_d;
  logic [EXP_W-1:0]   cnt_q, cnt_d;
  logic               sgn_q, sgn_d;
  logic [OUT_W-1:0]   out_data_q, out_data_d;
  logic               in_ready_q, in_ready_d;
  logic               out_valid_q, out_valid_d;
  logic               busy_q, busy_d;

  always_comb begin
    state_d    = state_q;
    mag_d      = mag_q;
    cnt_d      = cnt_q;
    sgn_d      = sgn_q;
    out_data_d = out_data_q;

    case (state_q)
      IDLE: begin
        // Accept is qualified by the registered ready so a just-reset block never accepts.
        if (in_valid && in_ready_q) begin
          mag_d   = {{(OUT_W-SIG_W){1'b0}}, in_sig};
          cnt_d   = in_exp;
          sgn_d   = in_sign;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        if (cnt_q != '0) begin
          mag_d = mag_q << 1;
          cnt_d = cnt_q - EXP_W'(1);
        end else begin
          out_data_d = sgn_q ? (~mag_q + OUT_W'(1)) : mag_q;
          state_d    = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // Handshake outputs are registered copies of the next-state decode.
    in_ready_d  = (state_d == IDLE);
    out_valid_d = (state_d == DONE);
    busy_d      = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      mag_q       <= '0;
      cnt_q       <= '0;
      sgn_q       <= 1'b0;
      out_data_q  <= '0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      mag_q       <= mag_d;
      cnt_q       <= cnt_d;
      sgn_q       <= sgn_d;
      out_data_q  <= out_data_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign busy      = busy_q;

endmodule

`default_nettype wire
